// File: rtl/encrypt_pkg.sv
// Shared encrypter/decrypter definitions: mode encoding, default widths,
// LFSR defaults and output-frame field offsets.
package encrypt_pkg;

  localparam int unsigned DATA_W_DEF   = 60;
  localparam int unsigned RAND_A_W_DEF = 6;
  localparam int unsigned RAND_B_W_DEF = 11;
  localparam int unsigned LFSR_W_DEF   = RAND_A_W_DEF + RAND_B_W_DEF;
  localparam int unsigned OUT_W_DEF    = DATA_W_DEF + LFSR_W_DEF + 1;

  localparam logic [LFSR_W_DEF-1:0] LFSR_TAPS_DEF = 17'h12000;
  localparam logic [LFSR_W_DEF-1:0] SEED_DEF      = 17'h00001;

  typedef enum logic [1:0] {
    MODE_XOR     = 2'd0,
    MODE_ROT     = 2'd1,
    MODE_XOR_ROT = 2'd2,
    MODE_ADD     = 2'd3
  } mode_e;

  // Frame layout, LSB first: parity, rand_a, rand_b, cipher
  localparam int unsigned PARITY_LSB = 0;
  localparam int unsigned RAND_A_LSB = 1;
  localparam int unsigned RAND_B_LSB = RAND_A_LSB + RAND_A_W_DEF;
  localparam int unsigned CIPHER_LSB = RAND_B_LSB + RAND_B_W_DEF;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]   cipher;
    logic [RAND_B_W_DEF-1:0] rand_b;
    logic [RAND_A_W_DEF-1:0] rand_a;
    logic                    parity;
  } frame_t;

endpackage

// File: rtl/encrypt_engine_if.sv
// Plaintext-in / frame-out handshake bus plus reseed request.
interface encrypt_engine_if
  import encrypt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LFSR_W = LFSR_W_DEF,
  parameter int unsigned OUT_W  = DATA_W + LFSR_W + 1
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              mode_auto;
  logic [1:0]        mode_sel;
  logic              reseed_valid;
  logic [LFSR_W-1:0] reseed_value;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_frame;

  modport master (
    output in_valid, in_data, mode_auto, mode_sel, reseed_valid, reseed_value, out_ready,
    input  in_ready, out_valid, out_frame
  );

  modport slave (
    input  in_valid, in_data, mode_auto, mode_sel, reseed_valid, reseed_value, out_ready,
    output in_ready, out_valid, out_frame
  );

endinterface

// File: rtl/encrypt_engine_lfsr_keygen.sv
// Fibonacci key LFSR: advances once per accepted word, reseed wins over advance,
// a zero seed is replaced by 1 so the register never locks up.
module lfsr_keygen
  import encrypt_pkg::*;
#(
  parameter int unsigned       LFSR_W    = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(SEED_DEF)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              advance,
  input  logic              reseed_valid,
  input  logic [LFSR_W-1:0] reseed_value,
  output logic [LFSR_W-1:0] lfsr
);

  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] reseed_safe_c;
  logic              feedback_c;

  assign reseed_safe_c = (reseed_value == '0) ? LFSR_W'(1) : reseed_value;
  assign feedback_c    = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      lfsr <= SEED_SAFE;
    end else if (reseed_valid) begin
      lfsr <= reseed_safe_c;
    end else if (advance) begin
      lfsr <= {lfsr[LFSR_W-2:0], feedback_c};
    end
  end

endmodule

// File: rtl/encrypt_engine.sv
// Two-stage keyed encrypter: S1 captures data/key/mode, S2 registers the
// {cipher, rand_b, rand_a, parity} frame under valid/ready back-pressure.
module encrypt_engine
  import encrypt_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       RAND_A_W  = RAND_A_W_DEF,
  parameter int unsigned       RAND_B_W  = RAND_B_W_DEF,
  parameter int unsigned       LFSR_W    = RAND_A_W + RAND_B_W,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(SEED_DEF),
  parameter int unsigned       OUT_W     = DATA_W + LFSR_W + 1
) (
  input logic              Clk,
  input logic              Rst,
  encrypt_engine_if.slave  bus
);

  if (DATA_W <= LFSR_W) begin : g_chk_data_w
    $error("encrypt_engine: DATA_W must exceed LFSR_W");
  end
  if ((64'd1 << RAND_A_W) >= 64'(2 * DATA_W)) begin : g_chk_rot_w
    $error("encrypt_engine: rotate key too wide for single conditional subtract");
  end
  if (RAND_B_W < 2) begin : g_chk_rand_b_w
    $error("encrypt_engine: RAND_B_W must be at least 2");
  end

  logic [LFSR_W-1:0]   lfsr;
  logic [RAND_B_W-1:0] rand_b_c;
  logic [LFSR_W-1:0]   key_c;
  logic                s2_en_c;
  logic                in_ready_c;
  logic                accept_c;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_data;
  logic [LFSR_W-1:0]   s1_key;
  mode_e               s1_mode;

  logic [DATA_W-1:0]   k_rep_c;
  logic [31:0]         rot_amt_c;
  logic [DATA_W-1:0]   xored_c;
  logic [DATA_W-1:0]   rot_src_c;
  logic [2*DATA_W-1:0] rot_wide_c;
  logic [DATA_W-1:0]   cipher_c;
  logic [OUT_W-1:0]    frame_c;

  // S1 may load whenever it is empty or S2 is about to hand its frame off
  assign s2_en_c      = !bus.out_valid || bus.out_ready;
  assign in_ready_c   = !Rst && (!s1_valid || s2_en_c);
  assign accept_c     = bus.in_valid && in_ready_c;
  assign bus.in_ready = in_ready_c;

  lfsr_keygen #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .SEED      (SEED)
  ) u_keygen (
    .Clk          (Clk),
    .Rst          (Rst),
    .advance      (accept_c),
    .reseed_valid (bus.reseed_valid),
    .reseed_value (bus.reseed_value),
    .lfsr         (lfsr)
  );

  // Manual mode overrides the two mode bits inside rand_b
  always_comb begin
    rand_b_c = lfsr[LFSR_W-1:RAND_A_W];
    if (!bus.mode_auto) begin
      rand_b_c[1:0] = bus.mode_sel;
    end
    key_c = {rand_b_c, lfsr[RAND_A_W-1:0]};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept_c) begin
      s1_data <= bus.in_data;
      s1_key  <= key_c;
      s1_mode <= mode_e'(key_c[RAND_A_W +: 2]);
    end
  end

  // Key replicated from bit 0 upward and truncated to the data width
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rep
    assign k_rep_c[gi] = s1_key[gi % LFSR_W];
  end

  always_comb begin
    rot_amt_c = 32'(s1_key[RAND_A_W-1:0]);
    if (rot_amt_c >= DATA_W) begin
      rot_amt_c = rot_amt_c - DATA_W;
    end
    xored_c    = s1_data ^ k_rep_c;
    rot_src_c  = (s1_mode == MODE_ROT) ? s1_data : xored_c;
    rot_wide_c = {rot_src_c, rot_src_c} << rot_amt_c;
    cipher_c   = xored_c;
    case (s1_mode)
      MODE_XOR:     cipher_c = xored_c;
      MODE_ROT,
      MODE_XOR_ROT: cipher_c = rot_wide_c[2*DATA_W-1 -: DATA_W];
      MODE_ADD:     cipher_c = s1_data + k_rep_c;
      default:      cipher_c = xored_c;
    endcase
    frame_c = {cipher_c, s1_key, ^{cipher_c, s1_key}};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.out_valid <= 1'b0;
      bus.out_frame <= '0;
    end else if (s2_en_c) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_frame <= frame_c;
      end
    end
  end

endmodule

// File: tb/tb_encrypt_engine.sv
// Randomized self-checking bench for encrypt_engine against a behavioural
// model of keying, ciphering, framing and flow control.
module tb_encrypt_engine;
  import encrypt_pkg::*;

  localparam logic [16:0] SEED = 17'h00001;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  encrypt_engine_if bus ();

  encrypt_engine dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_frames = 0;
  logic [16:0] m_lfsr   = SEED;
  logic [77:0] exp_q[$];
  logic [59:0] dat_q[$];
  logic        stall_prev = 1'b0;
  logic [77:0] held = '0;
  logic [77:0] last_frame = '0;
  logic        accepted = 1'b0;
  logic        saw_block = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] lfsr_step(input logic [16:0] l);
    return {l[15:0], ^(l & 17'h12000)};
  endfunction

  function automatic logic [59:0] rep_key(input logic [16:0] k);
    logic [59:0] r;
    for (int i = 0; i < 60; i++) r[i] = k[i % 17];
    return r;
  endfunction

  function automatic logic [59:0] rotl(input logic [59:0] x, input int r);
    return (x << r) | (x >> (60 - r));
  endfunction

  function automatic logic [59:0] rotr(input logic [59:0] x, input int r);
    return (x >> r) | (x << (60 - r));
  endfunction

  function automatic logic [77:0] model_frame(input logic [59:0] d, input logic [16:0] l,
                                              input logic ma, input logic [1:0] ms);
    logic [5:0]  ra;
    logic [10:0] rb;
    logic [59:0] k;
    logic [59:0] c;
    int          r;
    ra = l[5:0];
    rb = l[16:6];
    if (!ma) rb[1:0] = ms;
    k = rep_key({rb, ra});
    r = int'(ra) % 60;
    case (rb[1:0])
      2'd0:    c = d ^ k;
      2'd1:    c = rotl(d, r);
      2'd2:    c = rotl(d ^ k, r);
      default: c = d + k;
    endcase
    return {c, rb, ra, ^{c, rb, ra}};
  endfunction

  function automatic logic [59:0] decrypt(input logic [77:0] fr);
    frame_t      f;
    logic [59:0] k;
    int          r;
    f = fr;
    k = rep_key({f.rand_b, f.rand_a});
    r = int'(f.rand_a) % 60;
    case (f.rand_b[1:0])
      2'd0:    return f.cipher ^ k;
      2'd1:    return rotr(f.cipher, r);
      2'd2:    return rotr(f.cipher, r) ^ k;
      default: return f.cipher - k;
    endcase
  endfunction

  function automatic logic [59:0] rand60();
    return 60'({$urandom(), $urandom()});
  endfunction

  // One clock: observe at the falling edge, then return just after the rising edge
  task automatic tick();
    logic [77:0] f;
    logic [59:0] d;
    @(negedge Clk);
    accepted = 1'b0;
    if (Rst) begin
      check_eq("rst_in_ready", 128'(bus.in_ready), 128'(0));
      exp_q.delete();
      dat_q.delete();
      m_lfsr     = SEED;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check_eq("stall_stable", 128'(bus.out_frame), 128'(held));
      if (bus.out_valid && bus.out_ready) begin
        n_frames++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 128'(bus.out_valid), 128'(0));
        end else begin
          f = exp_q.pop_front();
          d = dat_q.pop_front();
          check_eq("frame", 128'(bus.out_frame), 128'(f));
          check_eq("parity", 128'(^bus.out_frame), 128'(0));
          check_eq("decrypt", 128'(decrypt(bus.out_frame)), 128'(d));
          last_frame = bus.out_frame;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = bus.out_frame;
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        accepted = 1'b1;
        exp_q.push_back(model_frame(bus.in_data, m_lfsr, bus.mode_auto, bus.mode_sel));
        dat_q.push_back(bus.in_data);
      end
      if (bus.reseed_valid) m_lfsr = (bus.reseed_value == '0) ? 17'h1 : bus.reseed_value;
      else if (accepted)    m_lfsr = lfsr_step(m_lfsr);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.reseed_valid = 1'b0;
    repeat (n) tick();
    Rst = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.reseed_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check_eq("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int          sent;
    int          frames0;
    logic [16:0] l_exp;
    logic [59:0] cur;

    Rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.mode_auto = 1'b0;
    bus.mode_sel = 2'd0;
    bus.reseed_valid = 1'b0;
    bus.reseed_value = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check_eq("rst_out_frame", 128'(bus.out_frame), 128'(0));
    check_eq("rst_lfsr", 128'(dut.u_keygen.lfsr), 128'(SEED));

    // Zero data, XOR mode, seed key: fixed two-cycle latency and known frame
    Rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = '0;
    bus.mode_sel = 2'd0;
    tick();
    bus.in_valid = 1'b0;
    check_eq("lat1_valid", 128'(bus.out_valid), 128'(0));
    tick();
    check_eq("lat2_valid", 128'(bus.out_valid), 128'(1));
    check_eq("xor_seed_frame", 128'(bus.out_frame), 128'({60'h8000400020001, 11'h000, 6'h01, 1'b1}));
    drain();

    // Rotate mode with data 1, then a second word keyed by lfsr=2
    do_reset(1);
    bus.in_valid = 1'b1;
    bus.in_data = 60'h1;
    bus.mode_sel = 2'd1;
    tick();
    bus.in_data = rand60();
    bus.mode_sel = 2'($urandom_range(0, 3));
    tick();
    bus.in_valid = 1'b0;
    check_eq("rot_seed_frame", 128'(bus.out_frame), 128'({60'h2, 11'h001, 6'h01, 1'b1}));
    tick();
    check_eq("second_rand_a", 128'(bus.out_frame[6:1]), 128'(6'h02));
    drain();

    // Ten back-to-back words with a three-cycle output stall
    do_reset(1);
    bus.mode_auto = 1'($urandom_range(0, 1));
    bus.mode_sel = 2'($urandom_range(0, 3));
    sent = 0;
    saw_block = 1'b0;
    frames0 = n_frames;
    cur = rand60();
    for (int c = 0; c < 60 && (sent < 10 || exp_q.size() != 0); c++) begin
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid = (sent < 10);
      bus.in_data = cur;
      tick();
      if (accepted) begin
        sent++;
        cur = rand60();
      end
    end
    bus.in_valid = 1'b0;
    check_eq("burst_sent", 128'(sent), 128'(10));
    check_eq("burst_frames", 128'(n_frames - frames0), 128'(10));
    check_eq("burst_backpressure", 128'(saw_block), 128'(1));
    l_exp = SEED;
    for (int i = 0; i < 10; i++) l_exp = lfsr_step(l_exp);
    check_eq("burst_lfsr_steps", 128'(dut.u_keygen.lfsr), 128'(l_exp));
    drain();

    // Reseed to zero coinciding with an accept
    do_reset(1);
    bus.mode_auto = 1'b0;
    bus.mode_sel = 2'd0;
    bus.in_valid = 1'b1;
    bus.in_data = rand60();
    tick();
    bus.in_data = rand60();
    bus.reseed_valid = 1'b1;
    bus.reseed_value = '0;
    tick();
    check_eq("reseed_accepted", 128'(accepted), 128'(1));
    bus.reseed_valid = 1'b0;
    bus.in_data = rand60();
    tick();
    bus.in_valid = 1'b0;
    drain();
    check_eq("reseed_zero_key", 128'(last_frame[17:1]), 128'(17'h00001));

    // Reset with two words in flight discards both
    do_reset(1);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = rand60();
    tick();
    bus.in_data = rand60();
    tick();
    bus.in_valid = 1'b0;
    check_eq("inflight_valid", 128'(bus.out_valid), 128'(1));
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check_eq("flush_out_valid", 128'(bus.out_valid), 128'(0));
    bus.out_ready = 1'b1;
    frames0 = n_frames;
    repeat (4) tick();
    check_eq("flush_no_emit", 128'(n_frames - frames0), 128'(0));
    bus.in_valid = 1'b1;
    bus.in_data = rand60();
    tick();
    bus.in_valid = 1'b0;
    drain();
    check_eq("post_rst_key", 128'(last_frame[6:1]), 128'(SEED[5:0]));

    // Auto mode, random flow control and occasional reseeds
    do_reset(1);
    bus.mode_auto = 1'b1;
    sent = 0;
    for (int c = 0; c < 20000 && (sent < 1000 || exp_q.size() != 0); c++) begin
      bus.in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.in_data = rand60();
      bus.mode_sel = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.reseed_valid = ($urandom_range(0, 49) == 0);
      bus.reseed_value = ($urandom_range(0, 7) == 0) ? 17'h0 : 17'($urandom());
      tick();
      if (accepted) sent++;
    end
    check_eq("random_sent", 128'(sent), 128'(1000));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encrypt_engine.md
ENCRYPT_ENGINE -- requirements
Module: encrypt_engine

Interface
REQ-001 Parameters, each SHALL be: DATA_W (60, plaintext width); RAND_A_W (6, rotate-key width); RAND_B_W (11, XOR-key width); LFSR_W = RAND_A_W+RAND_B_W (17); LFSR_TAPS (17'h12000, Fibonacci tap mask, x^17+x^14+1); SEED (17'h00001, reset seed); OUT_W = DATA_W+LFSR_W+1 (78).
REQ-002 Constraints SHALL be: DATA_W > LFSR_W; 2^RAND_A_W < 2*DATA_W; RAND_B_W >= 2.
REQ-003 Ports SHALL be:
 Clk  in  1  clock, all logic on rising edge.
 Rst  in  1  synchronous, active-high reset.
 in_valid  in  1  plaintext word offered.
 in_ready  out  1  plaintext word accepted when in_valid & in_ready.
 in_data  in  DATA_W  plaintext.
 mode_auto  in  1  1 = mode taken from key; 0 = mode_sel forced into key; sampled with in_data.
 mode_sel  in  2  manual mode, sampled with in_data.
 reseed_valid  in  1  single-cycle reseed request.
 reseed_value  in  LFSR_W  new LFSR seed.
 out_valid  out  1  frame available.
 out_ready  in  1  frame consumed when out_valid & out_ready.
 out_frame  out  OUT_W  {cipher[DATA_W], rand_b[RAND_B_W], rand_a[RAND_A_W], parity}.

Function
REQ-004 Key LFSR SHALL be Fibonacci: next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}; it SHALL advance exactly once per accepted input word, never otherwise.
REQ-005 Per accepted word: rand_a = lfsr[RAND_A_W-1:0]; rand_b = lfsr[LFSR_W-1:RAND_A_W], except when mode_auto=0, where rand_b[1:0] SHALL be replaced by mode_sel; mode = rand_b[1:0] (post-replacement); key = {rand_b, rand_a}.
REQ-006 Replicated key K SHALL be key repeated from bit 0 upward, truncated to DATA_W; rotation r SHALL be rand_a mod DATA_W (single conditional subtract).
REQ-007 cipher SHALL be: mode 0 = data ^ K; mode 1 = data rotated left by r; mode 2 = (data ^ K) rotated left by r; mode 3 = (data + K) mod 2^DATA_W.
REQ-008 parity SHALL be XOR of all other OUT_W-1 frame bits.
REQ-009 Pipeline SHALL be two register stages (S1: data, key, mode; S2: out_frame); latency from accept to out_valid SHALL be exactly 2 cycles; throughput 1 word/cycle when out_ready=1.
REQ-010 in_ready SHALL be !s1_valid | (!out_valid | out_ready); no bubble insertion, no word dropped or duplicated.
REQ-011 While out_valid=1 and out_ready=0, out_frame SHALL stay stable; S1 SHALL hold its word.
REQ-012 reseed_valid SHALL load reseed_value into the LFSR at the next edge; if a word is accepted in the same cycle, that word SHALL use the pre-reseed LFSR value, and reseed takes priority over the advance.
REQ-013 Seed 0 (reset or reseed) SHALL load 1 instead; LFSR SHALL never hold 0.

Reset
REQ-014 Rst=1 SHALL set: lfsr = SEED (or 1 if SEED=0), S1/S2 valid = 0, out_valid = 0, out_frame = 0, in_ready = 0 while Rst=1.
REQ-015 Rst asserted mid-stream SHALL discard both in-flight words; first post-reset word SHALL use the seed key.

Structure
REQ-016 Package encrypt_pkg SHALL hold the mode enum (XOR, ROT, XOR_ROT, ADD), default widths, LFSR_TAPS and SEED defaults, and the frame-field offsets, shared with the decrypter.
REQ-017 Sub-module lfsr_keygen SHALL implement REQ-004/012/013/014 (LFSR only); encrypt_engine SHALL instantiate it once.

Verification
REQ-018 SEED=1, mode_auto=0, mode_sel=0, in_data=0, out_ready=1 -> 2 cycles later out_frame = {60'h8000400020001, 11'h000, 6'h01, 1'b1}.
REQ-019 SEED=1, mode_auto=0, mode_sel=1, in_data=60'h1 -> out_frame = {60'h2, 11'h001, 6'h01, 1'b1}; second word uses lfsr=17'h00002 (rand_a=6'h02).
REQ-020 10 back-to-back words, out_ready low for cycles 3-5 -> in_ready drops after S1/S2 fill, out_frame stable while stalled, all 10 frames delivered in order, LFSR advanced exactly 10 times.
REQ-021 reseed_valid with reseed_value=0 in same cycle as an accept -> that word keyed by old LFSR, next word keyed by lfsr=1.
REQ-022 Rst asserted for 1 cycle with 2 words in flight -> out_valid=0 next cycle, neither word emitted, next accepted word keyed by SEED.
REQ-023 mode_auto=1, 1000 random words -> each frame mode = rand_b[1:0], parity correct, reference model decrypt recovers in_data.
